// File: rtl/trap_controller.sv
// Trap-sequence controller: holds the ball when it enters a trap, restarts the
// countdown, counts escape key presses and reports escape or expiry. Also
// provides the blink enable for the on-screen countdown digit.
module trap_controller #(
  parameter int unsigned ESCAPE_PRESSES  = 5,
  parameter int unsigned COOLDOWN_CYCLES = 25000000,
  parameter int unsigned BLINK_THRESHOLD = 3,
  parameter int unsigned BLINK_PERIOD    = 6250000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       gameActive,
  input  logic       trapHit,
  input  logic       keyRelease,
  input  logic [3:0] countDownNumber,
  output logic       countEnable,
  output logic       countReset,
  output logic       ballHold,
  output logic       ballRelease,
  output logic       trapExpired,
  output logic       digitVisible,
  output logic [3:0] pressesLeft
);

  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int BL_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CD_W-1:0] CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST    = BL_W'(BLINK_PERIOD - 1);
  localparam logic [3:0]      PRESS_INIT = 4'(ESCAPE_PRESSES);
  localparam logic [3:0]      BLINK_TH   = 4'(BLINK_THRESHOLD);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COUNTING,
    ESCAPED,
    EXPIRED,
    COOLDOWN
  } state_t;

  state_t            state;
  logic              key_prev;
  logic [3:0]        presses_left;
  logic [BL_W-1:0]   blink_count;
  logic              blink_phase;
  logic [CD_W-1:0]   cooldown_count;
  logic              press;

  // A press is a rising edge of the release key; a key already high when
  // counting starts must fall and rise again before it counts.
  assign press = keyRelease & ~key_prev;

  // Trap sequencing, press counting, blink timing and cooldown timing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      key_prev       <= 1'b0;
      presses_left   <= 4'd0;
      blink_count    <= '0;
      blink_phase    <= 1'b1;
      cooldown_count <= '0;
    end else begin
      key_prev <= keyRelease;
      if (!gameActive) begin
        state          <= IDLE;
        presses_left   <= 4'd0;
        blink_count    <= '0;
        blink_phase    <= 1'b1;
        cooldown_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trapHit) state <= CAPTURE;
          end
          CAPTURE: begin
            presses_left <= PRESS_INIT;
            blink_count  <= '0;
            blink_phase  <= 1'b1;
            state        <= COUNTING;
          end
          COUNTING: begin
            if (blink_count == BL_LAST) begin
              blink_count <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_count <= blink_count + 1'b1;
            end
            if (press && presses_left != 4'd0) presses_left <= presses_left - 4'd1;
            // The final press wins over a countdown that reaches zero in the same cycle.
            if (press && presses_left == 4'd1) state <= ESCAPED;
            else if (countDownNumber == 4'd0) state <= EXPIRED;
          end
          ESCAPED, EXPIRED: begin
            cooldown_count <= '0;
            state          <= COOLDOWN;
          end
          COOLDOWN: begin
            if (cooldown_count == CD_LAST) begin
              cooldown_count <= '0;
              presses_left   <= 4'd0;
              state          <= IDLE;
            end else begin
              cooldown_count <= cooldown_count + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Moore outputs decoded from the registered state, so an asynchronous
  // reset releases the ball without waiting for a clock edge.
  assign countReset  = (state == CAPTURE);
  assign countEnable = (state == COUNTING);
  assign ballHold    = (state == CAPTURE) || (state == COUNTING);
  assign ballRelease = (state == ESCAPED);
  assign trapExpired = (state == EXPIRED);
  assign pressesLeft = presses_left;

  // Digit is steady above the threshold and blinks at or below it.
  assign digitVisible = (state == COUNTING) &&
                        ((countDownNumber > BLINK_TH) || blink_phase);

endmodule

// File: tb/tb_trap_controller.sv
// Directed testbench for trap_controller with short cooldown and blink timing.
module tb_trap_controller;

  logic       clk;
  logic       resetN;
  logic       gameActive;
  logic       trapHit;
  logic       keyRelease;
  logic [3:0] countDownNumber;
  logic       countEnable;
  logic       countReset;
  logic       ballHold;
  logic       ballRelease;
  logic       trapExpired;
  logic       digitVisible;
  logic [3:0] pressesLeft;

  int checks = 0;
  int errors = 0;

  trap_controller #(
    .ESCAPE_PRESSES (3),
    .COOLDOWN_CYCLES(8),
    .BLINK_THRESHOLD(3),
    .BLINK_PERIOD   (4)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .gameActive     (gameActive),
    .trapHit        (trapHit),
    .keyRelease     (keyRelease),
    .countDownNumber(countDownNumber),
    .countEnable    (countEnable),
    .countReset     (countReset),
    .ballHold       (ballHold),
    .ballRelease    (ballRelease),
    .trapExpired    (trapExpired),
    .digitVisible   (digitVisible),
    .pressesLeft    (pressesLeft)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are stable and inputs may change 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse trapHit for one cycle and land in CAPTURE.
  task automatic enter_capture();
    trapHit = 1'b1;
    tick();
    trapHit = 1'b0;
  endtask

  // One rising edge of the release key followed by its release.
  task automatic one_press();
    keyRelease = 1'b1;
    tick();
    keyRelease = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({countEnable, countReset, ballHold, ballRelease, trapExpired, digitVisible} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {countEnable, countReset, ballHold, ballRelease, trapExpired, digitVisible});
    end
    checks++;
    if (pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_presses: got %0d expected 0", pressesLeft);
    end
    #9 resetN = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_capture();
    enter_capture();
    checks++;
    if ({countReset, ballHold, countEnable} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL capture_cycle: got rst/hold/en=%b expected 110", {countReset, ballHold, countEnable});
    end
    tick();
    checks++;
    if ({countReset, ballHold, countEnable} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL counting_cycle: got rst/hold/en=%b expected 011", {countReset, ballHold, countEnable});
    end
    checks++;
    if (pressesLeft !== 4'd3) begin
      errors++;
      $display("[TB] FAIL capture_presses: got %0d expected 3", pressesLeft);
    end
  endtask

  task automatic test_escape();
    countDownNumber = 4'd7;
    one_press();
    checks++;
    if (pressesLeft !== 4'd2) begin
      errors++;
      $display("[TB] FAIL escape_press1: got %0d expected 2", pressesLeft);
    end
    one_press();
    checks++;
    if (pressesLeft !== 4'd1 || ballHold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL escape_press2: got presses=%0d hold=%b expected 1/1", pressesLeft, ballHold);
    end
    keyRelease = 1'b1;
    tick();
    keyRelease = 1'b0;
    checks++;
    if ({ballRelease, ballHold, countEnable} !== 3'b100 || pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL escape_release: got rel/hold/en=%b presses=%0d expected 100/0",
               {ballRelease, ballHold, countEnable}, pressesLeft);
    end
    trapHit = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({countReset, ballHold, ballRelease} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL cooldown_ignore_%0d: got rst/hold/rel=%b expected 000", i, {countReset, ballHold, ballRelease});
      end
    end
    tick();
    checks++;
    if (countReset !== 1'b0 || ballHold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cooldown_idle: got rst=%b hold=%b expected 0/0", countReset, ballHold);
    end
    tick();
    trapHit = 1'b0;
    checks++;
    if (countReset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL recapture: got countReset=%b expected 1", countReset);
    end
    tick();
  endtask

  task automatic test_expiry();
    one_press();
    for (int v = 5; v >= 1; v--) begin
      countDownNumber = 4'(v);
      tick();
      checks++;
      if (trapExpired !== 1'b0 || countEnable !== 1'b1) begin
        errors++;
        $display("[TB] FAIL expiry_early_%0d: got exp=%b en=%b expected 0/1", v, trapExpired, countEnable);
      end
    end
    countDownNumber = 4'd0;
    tick();
    countDownNumber = 4'd7;
    checks++;
    if ({trapExpired, ballRelease, ballHold} !== 3'b100 || pressesLeft !== 4'd2) begin
      errors++;
      $display("[TB] FAIL expiry_pulse: got exp/rel/hold=%b presses=%0d expected 100/2",
               {trapExpired, ballRelease, ballHold}, pressesLeft);
    end
    tick();
    checks++;
    if (trapExpired !== 1'b0 || pressesLeft !== 4'd2) begin
      errors++;
      $display("[TB] FAIL expiry_hold: got exp=%b presses=%0d expected 0/2", trapExpired, pressesLeft);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL expiry_idle_clear: got %0d expected 0", pressesLeft);
    end
  endtask

  task automatic test_tie();
    enter_capture();
    tick();
    one_press();
    one_press();
    keyRelease = 1'b1;
    countDownNumber = 4'd0;
    tick();
    keyRelease = 1'b0;
    countDownNumber = 4'd7;
    checks++;
    if (ballRelease !== 1'b1 || trapExpired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tie_result: got rel=%b exp=%b expected 1/0", ballRelease, trapExpired);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (trapExpired !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tie_no_expire_%0d: got %b expected 0", i, trapExpired);
      end
    end
  endtask

  task automatic test_key_held();
    keyRelease = 1'b1;
    enter_capture();
    tick();
    tick();
    checks++;
    if (pressesLeft !== 4'd3) begin
      errors++;
      $display("[TB] FAIL key_held: got %0d expected 3", pressesLeft);
    end
    keyRelease = 1'b0;
    tick();
    keyRelease = 1'b1;
    tick();
    keyRelease = 1'b0;
    checks++;
    if (pressesLeft !== 4'd2) begin
      errors++;
      $display("[TB] FAIL key_repress: got %0d expected 2", pressesLeft);
    end
  endtask

  task automatic test_abort();
    gameActive = 1'b0;
    trapHit = 1'b1;
    tick();
    trapHit = 1'b0;
    checks++;
    if ({ballHold, countEnable, ballRelease, trapExpired} !== 4'b0000 || pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got hold/en/rel/exp=%b presses=%0d expected 0000/0",
               {ballHold, countEnable, ballRelease, trapExpired}, pressesLeft);
    end
    gameActive = 1'b1;
    tick();
    checks++;
    if ({countReset, ballRelease, trapExpired} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_after: got rst/rel/exp=%b expected 000", {countReset, ballRelease, trapExpired});
    end
  endtask

  task automatic test_blink();
    logic expected;
    countDownNumber = 4'd5;
    enter_capture();
    checks++;
    if (digitVisible !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blink_capture: got %b expected 0", digitVisible);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (digitVisible !== 1'b1) begin
        errors++;
        $display("[TB] FAIL blink_steady_%0d: got %b expected 1", i, digitVisible);
      end
      tick();
    end
    test_abort();
    countDownNumber = 4'd3;
    enter_capture();
    tick();
    for (int i = 0; i < 12; i++) begin
      expected = ((i / 4) % 2) == 0;
      checks++;
      if (digitVisible !== expected) begin
        errors++;
        $display("[TB] FAIL blink_pattern_%0d: got %b expected %b", i, digitVisible, expected);
      end
      tick();
    end
    test_abort();
    #1;
    checks++;
    if (digitVisible !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blink_idle: got %b expected 0", digitVisible);
    end
    countDownNumber = 4'd7;
  endtask

  task automatic test_async_reset();
    enter_capture();
    tick();
    #1 resetN = 1'b0;
    #1;
    checks++;
    if (ballHold !== 1'b0 || countEnable !== 1'b0 || pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_counting: got hold=%b en=%b presses=%0d expected 0/0/0", ballHold, countEnable, pressesLeft);
    end
    #2 resetN = 1'b1;
    tick();
    countDownNumber = 4'd0;
    enter_capture();
    tick();
    tick();
    countDownNumber = 4'd7;
    checks++;
    if (trapExpired !== 1'b1) begin
      errors++;
      $display("[TB] FAIL immediate_expire: got %b expected 1", trapExpired);
    end
    tick();
    checks++;
    if (pressesLeft !== 4'd3) begin
      errors++;
      $display("[TB] FAIL cooldown_presses: got %0d expected 3", pressesLeft);
    end
    #1 resetN = 1'b0;
    #1;
    checks++;
    if ({countEnable, countReset, ballHold, ballRelease, trapExpired, digitVisible} !== 6'b0 || pressesLeft !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_cooldown: got %b presses=%0d expected 000000/0",
               {countEnable, countReset, ballHold, ballRelease, trapExpired, digitVisible}, pressesLeft);
    end
    #2 resetN = 1'b1;
    tick();
    enter_capture();
    checks++;
    if (countReset !== 1'b1 || ballHold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_recapture: got rst=%b hold=%b expected 1/1", countReset, ballHold);
    end
    tick();
  endtask

  // Scenario sequence.
  initial begin
    resetN          = 1'b0;
    gameActive      = 1'b1;
    trapHit         = 1'b0;
    keyRelease      = 1'b0;
    countDownNumber = 4'd7;
    test_reset();
    test_capture();
    test_escape();
    test_expiry();
    test_tie();
    test_key_held();
    test_abort();
    test_blink();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Trap-sequence controller that consumes count_down's countDownNumber and drives its enable/resetCounter inputs.
- On a trap hit it holds the ball, restarts the countdown and counts player key presses.
- The player escapes with ESCAPE_PRESSES presses before the countdown reaches 0; otherwise it signals expiry (life lost).
- Also drives a blink-enable for the on-screen countdown digit. Sits between the collision logic and count_down / trap digit drawer.

Parameters:
- ESCAPE_PRESSES, 5, release-key rising edges required to escape (1..15)
- COOLDOWN_CYCLES, 25000000, cycles trapHit is ignored after escape/expiry
- BLINK_THRESHOLD, 3, countDownNumber at or below which the digit blinks
- BLINK_PERIOD, 6250000, cycles per blink half-period

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- gameActive  in  1  level; low forces IDLE
- trapHit  in  1  one-cycle pulse, ball entered trap region
- keyRelease  in  1  release key level, synchronous to clk
- countDownNumber  in  4  current value from count_down
- countEnable  out  1  to count_down enable
- countReset  out  1  to count_down resetCounter
- ballHold  out  1  freeze ball motion
- ballRelease  out  1  one-cycle pulse, escape succeeded
- trapExpired  out  1  one-cycle pulse, countdown hit 0
- digitVisible  out  1  draw countdown digit this cycle
- pressesLeft  out  4  presses still required

Behaviour:
- Reset is asynchronous (resetN low): state=IDLE, pressesLeft=0, blink counter=0, blink phase=1, cooldown counter=0, keyRelease history register=0. All outputs 0.
- Outputs are Moore, decoded from registered state:
  - countReset = CAPTURE
  - countEnable = COUNTING
  - ballHold = CAPTURE or COUNTING
  - ballRelease = ESCAPED
  - trapExpired = EXPIRED
- IDLE: trapHit -> CAPTURE. Other inputs ignored.
- CAPTURE (exactly 1 cycle): pressesLeft <= ESCAPE_PRESSES; blink counter cleared, phase=1; -> COUNTING.
- Latency: trapHit high at cycle N -> countReset and ballHold high at N+1 -> countEnable high from N+2. count_down loads a fresh value at the N+1 edge, so it is valid in COUNTING.
- COUNTING, evaluated in priority order each cycle:
  1. Key press: a press is rising edge of keyRelease (registered previous value). pressesLeft decrements on a press, saturating at 0. A press that takes pressesLeft 1->0 moves to ESCAPED next cycle.
  2. Expiry: else if countDownNumber==0 -> EXPIRED. Escape beats expiry in the same cycle.
  3. A countDownNumber of 0 on the first COUNTING cycle expires immediately, unless a final press arrives in that same cycle.
  4. trapHit is ignored.
- Key held high across CAPTURE counts as no press until it falls and rises again.
- ESCAPED / EXPIRED: 1 cycle each -> COOLDOWN; cooldown counter cleared.
- COOLDOWN: counter increments. At COOLDOWN_CYCLES-1 -> IDLE. trapHit ignored throughout. Counter width = clog2(COOLDOWN_CYCLES).
- digitVisible:
  - 0 outside COUNTING.
  - In COUNTING, 1 while countDownNumber > BLINK_THRESHOLD.
  - Otherwise equals blink phase, which toggles every BLINK_PERIOD cycles, starting at 1.
  - Blink counter runs only in COUNTING.
- pressesLeft holds its value through ESCAPED/EXPIRED/COOLDOWN and is cleared to 0 on entering IDLE.
- gameActive low in any state: next state IDLE, no ballRelease/trapExpired pulse, counters cleared. trapHit in the same cycle is ignored.
- Async reset mid-sequence returns to IDLE immediately; ballHold drops without waiting for clk.

Test Plan:
Sim parameters: ESCAPE_PRESSES=3, COOLDOWN_CYCLES=8, BLINK_THRESHOLD=3, BLINK_PERIOD=4.
- Capture: trapHit at cycle 10 -> countReset=1 only in cycle 11; ballHold 1 from 11; countEnable 1 from 12; pressesLeft=3 at 12.
- Escape: 3 key rising edges during COUNTING, countDownNumber=7 -> pressesLeft 3,2,1,0. One-cycle ballRelease after the 3rd edge; ballHold and countEnable 0 from then. trapHit during the next 8 cycles is ignored; trapHit at cycle +9 captures again.
- Expiry: 1 press, then countDownNumber driven 5..0 -> trapExpired one cycle after countDownNumber==0, pressesLeft stays 2, no ballRelease.
- Tie: 3rd press in the same cycle countDownNumber==0 -> ballRelease=1, trapExpired never asserted.
- Blink: countDownNumber=5 -> digitVisible steady 1. countDownNumber=3 -> digitVisible pattern 1111 0000 1111. IDLE -> 0.
- Abort / reset: gameActive low in COUNTING -> IDLE next cycle, no pulses. resetN low during COOLDOWN -> all outputs 0 immediately; after release, trapHit captures normally.
